// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32 memory stage: bus widths, EX->MEM bus layout,
// FSM state encodings and load funct3 codes.
package mem_stage_pkg;

  localparam int EX_TO_MEM_BUS_WD = 108;
  localparam int MEM_TO_WB_BUS_WD = 70;
  localparam int RDW_BUS_WD       = 39;

  // Field order matches the EX->MEM bus, MSB first.
  typedef struct packed {
    logic [31:0] rf_rdata2;
    logic [31:0] result;
    logic [2:0]  funct3;
    logic        load;
    logic        store;
    logic        mem_wen;
    logic        wb_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] pc;
  } ex_mem_bus_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Aligns a loaded word by its byte offset and sign/zero-extends it by funct3.
// Purely combinational, no backpressure.
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] w_shifted;

  assign w_shifted = raw >> {offset, 3'b000};

  always_comb begin
    data = w_shifted;
    case (funct3)
      F3_LB:   data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_LH:   data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   data = w_shifted;
      F3_LBU:  data = {24'd0, w_shifted[7:0]};
      F3_LHU:  data = {16'd0, w_shifted[15:0]};
      default: data = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32 MEM stage: non-loads pass in one cycle, loads retire with the read response
// (zero-latency bypass); read data is held internally while WB stalls.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        WB_Allow_in,
  output logic                        MEM_Allow_in,
  input  logic                        EX_to_MEM_Valid,
  input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_Bus,
  input  logic [31:0]                 Read_data,
  input  logic                        Read_data_Valid,
  output logic                        Read_data_Ready,
  output logic                        MEM_to_WB_Valid,
  output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_Bus,
  output logic [RDW_BUS_WD-1:0]       rdw_MEM_Bus
);

  ex_mem_bus_t r_bus;
  mem_state_t  r_state;
  logic        r_mem_valid;
  logic [31:0] r_rdata;

  ex_mem_bus_t w_in_bus;
  mem_state_t  w_next_state;
  logic        w_accept;
  logic        w_rd_rdy;
  logic        w_rd_fire;
  logic        w_mem_ready;
  logic [31:0] w_raw;
  logic [31:0] w_ext;
  logic [31:0] w_wdata;
  logic        w_unused;

  assign w_in_bus  = ex_mem_bus_t'(EX_to_MEM_Bus);
  assign w_accept  = EX_to_MEM_Valid & MEM_Allow_in;
  assign w_rd_fire = w_rd_rdy & Read_data_Valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A new accept always wins; otherwise a load advances on its response and WB.
  always_comb begin
    w_next_state = r_state;
    if (w_accept) begin
      w_next_state = w_in_bus.load ? S_WAIT : S_IDLE;
    end else begin
      case (r_state)
        S_WAIT:  if (w_rd_fire) w_next_state = WB_Allow_in ? S_IDLE : S_HOLD;
        S_HOLD:  if (WB_Allow_in) w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd_rdy    = (r_state == S_WAIT) & r_mem_valid & r_bus.load;
    w_mem_ready = ~r_bus.load | (r_state == S_HOLD)
                | ((r_state == S_WAIT) & Read_data_Valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_valid <= 1'b0;
    end else if (MEM_Allow_in) begin
      r_mem_valid <= EX_to_MEM_Valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_bus <= w_in_bus;
    if (w_rd_fire) r_rdata <= Read_data;
  end

  assign w_raw = (r_state == S_HOLD) ? r_rdata : Read_data;

  mem_stage_load_extend u_load_extend (
    .raw    (w_raw),
    .offset (r_bus.result[1:0]),
    .funct3 (r_bus.funct3),
    .data   (w_ext)
  );

  assign w_wdata = r_bus.load ? w_ext : r_bus.result;

  assign Read_data_Ready = w_rd_rdy;
  assign MEM_to_WB_Valid = r_mem_valid & w_mem_ready;
  assign MEM_Allow_in    = ~r_mem_valid | (w_mem_ready & WB_Allow_in);
  assign MEM_to_WB_Bus   = {r_bus.wb_wen, r_bus.rf_waddr, w_wdata, r_bus.pc};
  assign rdw_MEM_Bus     = {~r_bus.load | w_mem_ready, r_bus.wb_wen & r_mem_valid,
                            r_bus.rf_waddr, w_wdata};

  assign w_unused = ^{r_bus.rf_rdata2, r_bus.store, r_bus.mem_wen};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a randomized stream checked
// against a transaction-level model of the stage.
module tb_mem_stage;

  logic         clk;
  logic         rst;
  logic         WB_Allow_in;
  logic         MEM_Allow_in;
  logic         EX_to_MEM_Valid;
  logic [107:0] EX_to_MEM_Bus;
  logic [31:0]  Read_data;
  logic         Read_data_Valid;
  logic         Read_data_Ready;
  logic         MEM_to_WB_Valid;
  logic [69:0]  MEM_to_WB_Bus;
  logic [38:0]  rdw_MEM_Bus;

  int errors = 0;
  int checks = 0;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .WB_Allow_in     (WB_Allow_in),
    .MEM_Allow_in    (MEM_Allow_in),
    .EX_to_MEM_Valid (EX_to_MEM_Valid),
    .EX_to_MEM_Bus   (EX_to_MEM_Bus),
    .Read_data       (Read_data),
    .Read_data_Valid (Read_data_Valid),
    .Read_data_Ready (Read_data_Ready),
    .MEM_to_WB_Valid (MEM_to_WB_Valid),
    .MEM_to_WB_Bus   (MEM_to_WB_Bus),
    .rdw_MEM_Bus     (rdw_MEM_Bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [107:0] mk(input logic [31:0] res, input logic [2:0] f3,
                                      input logic ld, input logic st, input logic ww,
                                      input logic [4:0] wa, input logic [31:0] pc);
    return {32'hA5A5_0000, res, f3, ld, st, st, ww, wa, pc};
  endfunction

  // Reference load result computed with plain arithmetic on byte/halfword values.
  function automatic logic [31:0] ref_ext(input logic [31:0] raw, input logic [1:0] off,
                                          input logic [2:0] f3);
    int unsigned w, b, h;
    w = raw >> (8 * off);
    b = w % 256;
    h = w % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    EX_to_MEM_Valid = 1'b0;
    EX_to_MEM_Bus   = '0;
    Read_data_Valid = 1'b0;
    Read_data       = '0;
    WB_Allow_in     = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    checks++; if (MEM_to_WB_Valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", MEM_to_WB_Valid); end
    checks++; if (Read_data_Ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", Read_data_Ready); end
    checks++; if (rdw_MEM_Bus[37] !== 1'b0) begin errors++; $display("FAIL reset_rdw_wen: got %b want 0", rdw_MEM_Bus[37]); end
    checks++; if (MEM_Allow_in !== 1'b1) begin errors++; $display("FAIL reset_allow_in: got %b want 1", MEM_Allow_in); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu;
    EX_to_MEM_Valid = 1'b1;
    EX_to_MEM_Bus   = mk(32'h5, 3'b000, 1'b0, 1'b0, 1'b1, 5'd3, 32'h100);
    tick();
    EX_to_MEM_Valid = 1'b0;
    @(negedge clk);
    checks++; if (MEM_to_WB_Valid !== 1'b1) begin errors++; $display("FAIL alu_valid: got %b want 1", MEM_to_WB_Valid); end
    checks++; if (MEM_to_WB_Bus !== {1'b1, 5'd3, 32'h5, 32'h100}) begin errors++; $display("FAIL alu_bus: got %h want %h", MEM_to_WB_Bus, {1'b1, 5'd3, 32'h5, 32'h100}); end
    checks++; if (rdw_MEM_Bus !== {1'b1, 1'b1, 5'd3, 32'h5}) begin errors++; $display("FAIL alu_rdw: got %h want %h", rdw_MEM_Bus, {1'b1, 1'b1, 5'd3, 32'h5}); end
    tick();
    @(negedge clk);
    checks++; if (MEM_to_WB_Valid !== 1'b0) begin errors++; $display("FAIL alu_drain: got %b want 0", MEM_to_WB_Valid); end
    tick();
  endtask

  task automatic test_lb_wait;
    EX_to_MEM_Valid = 1'b1;
    EX_to_MEM_Bus   = mk(32'h1001, 3'b000, 1'b1, 1'b0, 1'b1, 5'd7, 32'h104);
    tick();
    EX_to_MEM_Valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (Read_data_Ready !== 1'b1) begin errors++; $display("FAIL lb_ready_%0d: got %b want 1", i, Read_data_Ready); end
      checks++; if (rdw_MEM_Bus[38] !== 1'b0) begin errors++; $display("FAIL lb_data_ok_%0d: got %b want 0", i, rdw_MEM_Bus[38]); end
      checks++; if (MEM_to_WB_Valid !== 1'b0) begin errors++; $display("FAIL lb_early_valid_%0d: got %b want 0", i, MEM_to_WB_Valid); end
      tick();
    end
    Read_data_Valid = 1'b1;
    Read_data       = 32'h0000_80FF;
    @(negedge clk);
    checks++; if (MEM_to_WB_Valid !== 1'b1) begin errors++; $display("FAIL lb_valid: got %b want 1", MEM_to_WB_Valid); end
    checks++; if (MEM_to_WB_Bus[63:32] !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wdata: got %h want ffffff80", MEM_to_WB_Bus[63:32]); end
    checks++; if (rdw_MEM_Bus !== {1'b1, 1'b1, 5'd7, 32'hFFFF_FF80}) begin errors++; $display("FAIL lb_rdw: got %h want %h", rdw_MEM_Bus, {1'b1, 1'b1, 5'd7, 32'hFFFF_FF80}); end
    tick();
    Read_data_Valid = 1'b0;
    @(negedge clk);
    checks++; if (MEM_to_WB_Valid !== 1'b0) begin errors++; $display("FAIL lb_retired: got %b want 0", MEM_to_WB_Valid); end
    tick();
  endtask

  task automatic test_lhu_hold;
    EX_to_MEM_Valid = 1'b1;
    EX_to_MEM_Bus   = mk(32'h2002, 3'b101, 1'b1, 1'b0, 1'b1, 5'd9, 32'h108);
    tick();
    EX_to_MEM_Valid = 1'b0;
    Read_data_Valid = 1'b1;
    Read_data       = 32'hBEEF_0000;
    WB_Allow_in     = 1'b0;
    @(negedge clk);
    checks++; if (MEM_Allow_in !== 1'b0) begin errors++; $display("FAIL lhu_arrive_allow: got %b want 0", MEM_Allow_in); end
    checks++; if (MEM_to_WB_Bus[63:32] !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_arrive_wdata: got %h want 0000beef", MEM_to_WB_Bus[63:32]); end
    tick();
    for (int i = 0; i < 3; i++) begin
      // Spurious responses with other data while holding must not disturb the held word.
      Read_data_Valid = (i == 1);
      Read_data       = 32'h1234_5678 + i;
      @(negedge clk);
      checks++; if (Read_data_Ready !== 1'b0) begin errors++; $display("FAIL lhu_hold_ready_%0d: got %b want 0", i, Read_data_Ready); end
      checks++; if (MEM_Allow_in !== 1'b0) begin errors++; $display("FAIL lhu_hold_allow_%0d: got %b want 0", i, MEM_Allow_in); end
      checks++; if (MEM_to_WB_Valid !== 1'b1) begin errors++; $display("FAIL lhu_hold_valid_%0d: got %b want 1", i, MEM_to_WB_Valid); end
      checks++; if (MEM_to_WB_Bus[63:32] !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_hold_wdata_%0d: got %h want 0000beef", i, MEM_to_WB_Bus[63:32]); end
      tick();
    end
    Read_data_Valid = 1'b0;
    WB_Allow_in     = 1'b1;
    @(negedge clk);
    checks++; if (MEM_Allow_in !== 1'b1) begin errors++; $display("FAIL lhu_release_allow: got %b want 1", MEM_Allow_in); end
    checks++; if (MEM_to_WB_Bus !== {1'b1, 5'd9, 32'h0000_BEEF, 32'h108}) begin errors++; $display("FAIL lhu_release_bus: got %h want %h", MEM_to_WB_Bus, {1'b1, 5'd9, 32'h0000_BEEF, 32'h108}); end
    tick();
    @(negedge clk);
    checks++; if (MEM_to_WB_Valid !== 1'b0) begin errors++; $display("FAIL lhu_retired: got %b want 0", MEM_to_WB_Valid); end
    tick();
  endtask

  task automatic test_back_to_back;
    EX_to_MEM_Valid = 1'b1;
    EX_to_MEM_Bus   = mk(32'h200, 3'b010, 1'b1, 1'b0, 1'b1, 5'd1, 32'h10C);
    tick();
    EX_to_MEM_Bus   = mk(32'h204, 3'b010, 1'b1, 1'b0, 1'b1, 5'd2, 32'h110);
    Read_data_Valid = 1'b1;
    Read_data       = 32'h1111_1111;
    @(negedge clk);
    checks++; if (MEM_Allow_in !== 1'b1) begin errors++; $display("FAIL b2b_allow: got %b want 1", MEM_Allow_in); end
    checks++; if (MEM_to_WB_Bus !== {1'b1, 5'd1, 32'h1111_1111, 32'h10C}) begin errors++; $display("FAIL b2b_first: got %h want %h", MEM_to_WB_Bus, {1'b1, 5'd1, 32'h1111_1111, 32'h10C}); end
    tick();
    EX_to_MEM_Valid = 1'b0;
    Read_data       = 32'h2222_2222;
    @(negedge clk);
    checks++; if (Read_data_Ready !== 1'b1) begin errors++; $display("FAIL b2b_ready2: got %b want 1", Read_data_Ready); end
    checks++; if (MEM_to_WB_Valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2: got %b want 1", MEM_to_WB_Valid); end
    checks++; if (MEM_to_WB_Bus !== {1'b1, 5'd2, 32'h2222_2222, 32'h110}) begin errors++; $display("FAIL b2b_second: got %h want %h", MEM_to_WB_Bus, {1'b1, 5'd2, 32'h2222_2222, 32'h110}); end
    tick();
    Read_data_Valid = 1'b0;
    @(negedge clk);
    checks++; if (MEM_to_WB_Valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", MEM_to_WB_Valid); end
    tick();
  endtask

  task automatic test_store_then_load;
    EX_to_MEM_Valid = 1'b1;
    EX_to_MEM_Bus   = mk(32'h300, 3'b010, 1'b0, 1'b1, 1'b0, 5'd0, 32'h114);
    tick();
    EX_to_MEM_Bus   = mk(32'h303, 3'b100, 1'b1, 1'b0, 1'b1, 5'd4, 32'h118);
    Read_data_Valid = 1'b1;
    Read_data       = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (Read_data_Ready !== 1'b0) begin errors++; $display("FAIL st_ready: got %b want 0", Read_data_Ready); end
    checks++; if (MEM_to_WB_Valid !== 1'b1) begin errors++; $display("FAIL st_valid: got %b want 1", MEM_to_WB_Valid); end
    checks++; if (MEM_Allow_in !== 1'b1) begin errors++; $display("FAIL st_allow: got %b want 1", MEM_Allow_in); end
    checks++; if (rdw_MEM_Bus[37] !== 1'b0) begin errors++; $display("FAIL st_rdw_wen: got %b want 0", rdw_MEM_Bus[37]); end
    tick();
    EX_to_MEM_Valid = 1'b0;
    Read_data_Valid = 1'b0;
    @(negedge clk);
    checks++; if (rdw_MEM_Bus[38] !== 1'b0) begin errors++; $display("FAIL ld_after_st_data_ok: got %b want 0", rdw_MEM_Bus[38]); end
    checks++; if (Read_data_Ready !== 1'b1) begin errors++; $display("FAIL ld_after_st_ready: got %b want 1", Read_data_Ready); end
    tick();
    Read_data_Valid = 1'b1;
    Read_data       = 32'hCAFE_F00D;
    @(negedge clk);
    checks++; if (MEM_to_WB_Bus[63:32] !== 32'h0000_00CA) begin errors++; $display("FAIL ld_after_st_wdata: got %h want 000000ca", MEM_to_WB_Bus[63:32]); end
    tick();
    Read_data_Valid = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid_wait;
    EX_to_MEM_Valid = 1'b1;
    EX_to_MEM_Bus   = mk(32'h400, 3'b010, 1'b1, 1'b0, 1'b1, 5'd5, 32'h11C);
    tick();
    EX_to_MEM_Valid = 1'b0;
    @(negedge clk);
    checks++; if (Read_data_Ready !== 1'b1) begin errors++; $display("FAIL rst_pre_ready: got %b want 1", Read_data_Ready); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    Read_data_Valid = 1'b1;
    Read_data       = 32'h5555_AAAA;
    @(negedge clk);
    checks++; if (MEM_to_WB_Valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b want 0", MEM_to_WB_Valid); end
    checks++; if (Read_data_Ready !== 1'b0) begin errors++; $display("FAIL rst_rd_ready: got %b want 0", Read_data_Ready); end
    checks++; if (MEM_Allow_in !== 1'b1) begin errors++; $display("FAIL rst_allow: got %b want 1", MEM_Allow_in); end
    checks++; if (rdw_MEM_Bus[37] !== 1'b0) begin errors++; $display("FAIL rst_rdw_wen: got %b want 0", rdw_MEM_Bus[37]); end
    tick();
    Read_data_Valid = 1'b0;
    tick();
  endtask

  // Model holds at most one instruction in the stage, plus whether its load data has arrived.
  task automatic test_random;
    logic         have, got, pend, ld, st, ww, exp_rdy, exp_mr, exp_allow;
    logic [107:0] m_inst, nxt;
    logic [31:0]  m_data, raw, exp_wdata;
    logic [2:0]   f3;
    logic [4:0]   wa;
    have = 1'b0; got = 1'b0; pend = 1'b0;
    m_inst = '0; nxt = '0; m_data = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        ld  = 1'($urandom_range(0, 1));
        st  = ~ld & 1'($urandom_range(0, 1));
        ww  = 1'($urandom_range(0, 1));
        f3  = 3'($urandom_range(0, 7));
        wa  = 5'($urandom_range(0, 31));
        nxt = mk($urandom, f3, ld, st, ww, wa, $urandom);
        pend = 1'b1;
      end
      EX_to_MEM_Valid = pend;
      EX_to_MEM_Bus   = nxt;
      WB_Allow_in     = ($urandom_range(0, 3) != 0);
      Read_data_Valid = ($urandom_range(0, 2) == 0);
      Read_data       = $urandom;
      @(negedge clk);
      exp_rdy   = have & m_inst[40] & ~got;
      exp_mr    = ~m_inst[40] | got | (exp_rdy & Read_data_Valid);
      exp_allow = ~have | (exp_mr & WB_Allow_in);
      raw       = got ? m_data : Read_data;
      exp_wdata = m_inst[40] ? ref_ext(raw, m_inst[45:44], m_inst[43:41]) : m_inst[75:44];
      checks++; if (Read_data_Ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, Read_data_Ready, exp_rdy); end
      checks++; if (MEM_Allow_in !== exp_allow) begin errors++; $display("FAIL rnd_allow c=%0d: got %b want %b", c, MEM_Allow_in, exp_allow); end
      checks++; if (MEM_to_WB_Valid !== (have & exp_mr)) begin errors++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, MEM_to_WB_Valid, have & exp_mr); end
      checks++; if (rdw_MEM_Bus[37] !== (have & m_inst[37])) begin errors++; $display("FAIL rnd_rdw_wen c=%0d: got %b want %b", c, rdw_MEM_Bus[37], have & m_inst[37]); end
      if (have) begin
        checks++; if (rdw_MEM_Bus[38] !== exp_mr) begin errors++; $display("FAIL rnd_data_ok c=%0d: got %b want %b", c, rdw_MEM_Bus[38], exp_mr); end
      end
      if (have && exp_mr) begin
        checks++; if (MEM_to_WB_Bus !== {m_inst[37], m_inst[36:32], exp_wdata, m_inst[31:0]}) begin errors++; $display("FAIL rnd_bus c=%0d: got %h want %h", c, MEM_to_WB_Bus, {m_inst[37], m_inst[36:32], exp_wdata, m_inst[31:0]}); end
        checks++; if (rdw_MEM_Bus[36:0] !== {m_inst[36:32], exp_wdata}) begin errors++; $display("FAIL rnd_rdw c=%0d: got %h want %h", c, rdw_MEM_Bus[36:0], {m_inst[36:32], exp_wdata}); end
      end
      if (have && exp_mr && WB_Allow_in) begin
        have = 1'b0;
      end else if (exp_rdy && Read_data_Valid) begin
        got    = 1'b1;
        m_data = Read_data;
      end
      if (pend && exp_allow) begin
        have   = 1'b1;
        got    = 1'b0;
        m_inst = nxt;
        pend   = 1'b0;
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_alu();
    test_lb_wait();
    test_lhu_hold();
    test_back_to_back();
    test_store_then_load();
    test_rst_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
